// File: rtl/alu_div_pkg.sv
// rtl/alu_div_pkg.sv - shared types and opcode constants for the iterative divider
package alu_div_pkg;

  typedef enum logic [2:0] {
    DIV_IDLE = 3'd0,
    DIV_PREP = 3'd1,
    DIV_ITER = 3'd2,
    DIV_FIX  = 3'd3,
    DIV_DONE = 3'd4
  } div_state_t;

  // Result cases that bypass the iteration loop entirely
  typedef enum logic [1:0] {
    SPC_NONE = 2'd0,
    SPC_DIV0 = 2'd1,
    SPC_OVF  = 2'd2
  } div_special_t;

  localparam logic OP_UDIV = 1'b0;
  localparam logic OP_DIV  = 1'b1;

endpackage

// File: rtl/alu_div_step.sv
// rtl/alu_div_step.sv - one combinational restoring-division step on {rem,q}
module alu_div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic [WIDTH-1:0] q_next
);

  logic [WIDTH:0] rem_sh;
  logic           fits;

  assign rem_sh = {rem, q[WIDTH-1]};
  assign fits   = (rem_sh >= {1'b0, divisor});

  // When the trial succeeds the true difference is below the divisor, so the low bits are exact
  assign rem_next = fits ? (rem_sh[WIDTH-1:0] - divisor) : rem_sh[WIDTH-1:0];
  assign q_next   = {q[WIDTH-2:0], fits};

endmodule

// File: rtl/alu_div.sv
// rtl/alu_div.sv - iterative signed/unsigned restoring divider with start/busy/done handshake
module alu_div
  import alu_div_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter bit SIGNED_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic             start,
  input  logic             signed_op,
  input  logic             abort,
  input  logic [WIDTH-1:0] din_a,
  input  logic [WIDTH-1:0] din_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div0_out,
  output logic             vout
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  div_state_t   state, next_state;
  div_special_t special;

  logic [WIDTH-1:0] a_r, b_r, rem_r, q_r;
  logic [CW-1:0]    cnt;
  logic             op_s, sign_q, sign_r;

  logic             accept, abort_hit;
  logic [WIDTH-1:0] neg_in0, neg_in1, neg0, neg1;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic             is_div0, is_ovf;
  logic [WIDTH-1:0] step_rem, step_q;

  assign abort_hit = abort && (state != DIV_IDLE);
  assign accept    = start && !abort && ((state == DIV_IDLE) || (state == DIV_DONE));

  // Two negators serve both phases: operand magnitudes in PREP, result sign fix-up in FIX
  assign neg_in0 = (state == DIV_PREP) ? a_r : q_r;
  assign neg_in1 = (state == DIV_PREP) ? b_r : rem_r;
  assign neg0    = -neg_in0;
  assign neg1    = -neg_in1;

  assign a_mag   = (op_s && a_r[WIDTH-1]) ? neg0 : a_r;
  assign b_mag   = (op_s && b_r[WIDTH-1]) ? neg1 : b_r;
  assign is_div0 = (b_r == '0);
  assign is_ovf  = op_s && (a_r == MIN_VAL) && (b_r == '1);

  alu_div_step #(.WIDTH(WIDTH)) u_step (
    .rem      (rem_r),
    .q        (q_r),
    .divisor  (b_r),
    .rem_next (step_rem),
    .q_next   (step_q)
  );

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) state <= DIV_IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      DIV_IDLE: if (accept) next_state = DIV_PREP;
      DIV_PREP: next_state = (is_div0 || is_ovf) ? DIV_FIX : DIV_ITER;
      DIV_ITER: if (cnt == '0) next_state = DIV_FIX;
      DIV_FIX:  next_state = DIV_DONE;
      DIV_DONE: next_state = accept ? DIV_PREP : DIV_IDLE;
      default:  next_state = DIV_IDLE;
    endcase
    if (abort_hit) next_state = DIV_IDLE;
  end

  always_comb begin
    busy = (state == DIV_PREP) || (state == DIV_ITER) || (state == DIV_FIX);
    done = (state == DIV_DONE);
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      a_r       <= '0;
      b_r       <= '0;
      rem_r     <= '0;
      q_r       <= '0;
      cnt       <= '0;
      op_s      <= 1'b0;
      sign_q    <= 1'b0;
      sign_r    <= 1'b0;
      special   <= SPC_NONE;
      quotient  <= '0;
      remainder <= '0;
      div0_out  <= 1'b0;
      vout      <= 1'b0;
    end else if (accept) begin
      a_r  <= din_a;
      b_r  <= din_b;
      op_s <= SIGNED_EN && (signed_op == OP_DIV);
    end else begin
      unique case (state)
        DIV_PREP: begin
          sign_q  <= op_s && (a_r[WIDTH-1] ^ b_r[WIDTH-1]);
          sign_r  <= op_s && a_r[WIDTH-1];
          special <= is_div0 ? SPC_DIV0 : (is_ovf ? SPC_OVF : SPC_NONE);
          rem_r   <= '0;
          q_r     <= a_mag;
          b_r     <= b_mag;
          cnt     <= CW'(WIDTH - 1);
        end
        DIV_ITER: begin
          rem_r <= step_rem;
          q_r   <= step_q;
          cnt   <= cnt - CW'(1);
        end
        DIV_FIX: begin
          if (!abort) begin
            unique case (special)
              SPC_DIV0: begin
                quotient  <= '1;
                remainder <= a_r;
                div0_out  <= 1'b1;
                vout      <= 1'b0;
              end
              SPC_OVF: begin
                quotient  <= MIN_VAL;
                remainder <= '0;
                div0_out  <= 1'b0;
                vout      <= 1'b1;
              end
              default: begin
                quotient  <= sign_q ? neg0 : q_r;
                remainder <= sign_r ? neg1 : rem_r;
                div0_out  <= 1'b0;
                vout      <= 1'b0;
              end
            endcase
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_div.sv
// tb/tb_alu_div.sv - directed-vector and model-based bench for alu_div
module tb_alu_div;

  logic        clk = 1'b0;
  logic        rstb, start, signed_op, abort;
  logic [31:0] din_a, din_b;
  logic        busy, done, div0_out, vout;
  logic [31:0] quotient, remainder;

  int n_cmp = 0;
  int n_bad = 0;

  alu_div #(.WIDTH(32), .SIGNED_EN(1'b1)) dut (
    .clk       (clk),
    .rstb      (rstb),
    .start     (start),
    .signed_op (signed_op),
    .abort     (abort),
    .din_a     (din_a),
    .din_b     (din_b),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .div0_out  (div0_out),
    .vout      (vout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        s;
    logic [31:0] eq;
    logic [31:0] er;
    logic        ed0;
    logic        ev;
    int          elat;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic launch(input logic [31:0] a, input logic [31:0] b, input logic s);
    din_a = a; din_b = b; signed_op = s; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // lat counts cycles after the start cycle; done must show up in cycle lat
  task automatic wait_done(input int lat0, output int lat);
    lat = lat0;
    while (!done && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!done) begin
      n_cmp++; n_bad++;
      $display("FAIL timeout: got no done, expected done within 200 cycles");
    end
  endtask

  task automatic model(input logic [31:0] a, input logic [31:0] b, input logic s,
                       output logic [31:0] q, output logic [31:0] r,
                       output logic d0, output logic v);
    logic signed [31:0] sa, sb;
    sa = a; sb = b; d0 = 1'b0; v = 1'b0;
    if (b == 0) begin
      q = '1; r = a; d0 = 1'b1;
    end else if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000; r = 0; v = 1'b1;
    end else if (s) begin
      q = sa / sb; r = sa % sb;
    end else begin
      q = a / b; r = a % b;
    end
  endtask

  initial begin
    int lat;
    int saw;
    logic [31:0] pq, pr, mq, mr;
    logic pd, pv, md, mv;

    vecs[0]  = '{32'd100,        32'd7,          1'b0, 32'd14,         32'd2,          1'b0, 1'b0, 35};
    vecs[1]  = '{32'hFFFF_FFF9,  32'd2,          1'b1, 32'hFFFF_FFFD,  32'hFFFF_FFFF,  1'b0, 1'b0, 35};
    vecs[2]  = '{32'hFFFF_FFF9,  32'd2,          1'b0, 32'h7FFF_FFFC,  32'd1,          1'b0, 1'b0, 35};
    vecs[3]  = '{32'h1234,       32'd0,          1'b0, 32'hFFFF_FFFF,  32'h1234,       1'b1, 1'b0, 3};
    vecs[4]  = '{32'h8000_0000,  32'hFFFF_FFFF,  1'b1, 32'h8000_0000,  32'd0,          1'b0, 1'b1, 3};
    vecs[5]  = '{32'h8000_0000,  32'hFFFF_FFFF,  1'b0, 32'd0,          32'h8000_0000,  1'b0, 1'b0, 35};
    vecs[6]  = '{32'd7,          32'hFFFF_FFFE,  1'b1, 32'hFFFF_FFFD,  32'd1,          1'b0, 1'b0, 35};
    vecs[7]  = '{32'hFFFF_FF9C,  32'hFFFF_FFF9,  1'b1, 32'd14,         32'hFFFF_FFFE,  1'b0, 1'b0, 35};
    vecs[8]  = '{32'd0,          32'd5,          1'b1, 32'd0,          32'd0,          1'b0, 1'b0, 35};
    vecs[9]  = '{32'hFFFF_FFFF,  32'd1,          1'b0, 32'hFFFF_FFFF,  32'd0,          1'b0, 1'b0, 35};
    vecs[10] = '{32'h1234,       32'd0,          1'b1, 32'hFFFF_FFFF,  32'h1234,       1'b1, 1'b0, 3};
    vecs[11] = '{32'h8000_0000,  32'd1,          1'b1, 32'h8000_0000,  32'd0,          1'b0, 1'b0, 35};
    vecs[12] = '{32'd5,          32'd10,         1'b0, 32'd0,          32'd5,          1'b0, 1'b0, 35};

    rstb = 1'b0; start = 1'b0; signed_op = 1'b0; abort = 1'b0; din_a = '0; din_b = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_state", {busy, done, div0_out, vout, quotient, remainder},
        {4'b0000, 64'h0});
    rstb = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 13; i++) begin
      launch(vecs[i].a, vecs[i].b, vecs[i].s);
      wait_done(1, lat);
      chk($sformatf("vec%0d_quotient", i), quotient, vecs[i].eq);
      chk($sformatf("vec%0d_remainder", i), remainder, vecs[i].er);
      chk($sformatf("vec%0d_flags", i), {div0_out, vout, busy}, {vecs[i].ed0, vecs[i].ev, 1'b0});
      chk($sformatf("vec%0d_latency", i), lat, vecs[i].elat);
      @(posedge clk); #1;
      chk($sformatf("vec%0d_done_pulse", i), {done, quotient}, {1'b0, vecs[i].eq});
    end

    // start while busy must be ignored
    launch(32'd100, 32'd7, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    chk("busy_mid_op", busy, 1'b1);
    din_a = 32'd1; din_b = 32'd1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(7, lat);
    chk("ignore_start_q", {quotient, remainder}, {32'd14, 32'd2});
    chk("ignore_start_lat", lat, 35);

    // back-to-back: start accepted in the DONE cycle
    din_a = 32'hFFFF_FFF9; din_b = 32'd2; signed_op = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("b2b_busy", {busy, done}, 2'b10);
    wait_done(1, lat);
    chk("b2b_result", {quotient, remainder}, {32'hFFFF_FFFD, 32'hFFFF_FFFF});
    chk("b2b_lat", lat, 35);
    @(posedge clk); #1;

    // abort during ITER: back to IDLE, no done, outputs untouched
    pq = 32'hFFFF_FFFD; pr = 32'hFFFF_FFFF;
    launch(32'd1000, 32'd3, 1'b0);
    repeat (11) @(posedge clk);
    #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("abort_idle", busy, 1'b0);
    saw = 0;
    for (int k = 0; k < 40; k++) begin
      if (done) saw = 1;
      @(posedge clk); #1;
    end
    chk("abort_no_done", saw, 0);
    chk("abort_hold", {quotient, remainder, div0_out, vout}, {pq, pr, 2'b00});

    // async reset mid-ITER
    launch(32'd1000, 32'd3, 1'b0);
    repeat (10) @(posedge clk);
    #2;
    rstb = 1'b0;
    #1;
    chk("rst_mid_iter", {busy, done, div0_out, vout, quotient, remainder}, {4'b0000, 64'h0});
    @(posedge clk); #1;
    rstb = 1'b1;
    @(posedge clk); #1;

    launch(32'd1000, 32'd3, 1'b0);
    wait_done(1, lat);
    chk("post_reset_op", {quotient, remainder, lat}, {32'd333, 32'd1, 32'd35});
    @(posedge clk); #1;

    // random soak against the reference model
    for (int n = 0; n < 1500; n++) begin
      logic [31:0] ra, rb;
      logic rs;
      ra = $urandom; rb = $urandom; rs = $urandom_range(0, 1);
      case ($urandom_range(0, 15))
        0: rb = 0;
        1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2: rb = $urandom_range(1, 15);
        3: rb = -$urandom_range(1, 15);
        default: ;
      endcase
      model(ra, rb, rs, mq, mr, md, mv);
      launch(ra, rb, rs);
      wait_done(1, lat);
      chk($sformatf("soak%0d a=%h b=%h s=%0d", n, ra, rb, rs),
          {quotient, remainder, div0_out, vout},
          {mq, mr, md, mv});
      if (n % 100 == 0)
        chk($sformatf("soak%0d_lat", n), lat, (md || mv) ? 3 : 35);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
